// File: rtl/axi_sram_slave_if.sv
// ============================================================================
//  Module      : axi_sram_slave_if
//  Description : AXI4 bundle (AW/W/B/AR/R) between the bus arbiter and the
//                SRAM slave. 32-bit addresses, 64-bit data, 4-bit ids.
//                master modport : arbiter side (drives valids, addresses,
//                                 write data and the B/R readies)
//                slave modport  : memory side (drives the AW/W/AR readies
//                                 and the B/R response channels)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_sram_slave_if;

    // Write address channel
    logic        awready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    // Write data channel
    logic        wready;
    logic        wvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;

    // Write response channel
    logic        bready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    // Read address channel
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    // Read data channel
    logic        rready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rresp, rdata, rlast, rid,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    modport slave (
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rresp, rdata, rlast, rid,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_sram_slave.sv
// ============================================================================
//  Module      : axi_sram_slave
//  Description : Single-outstanding AXI4 slave in front of a 64-bit SRAM
//                array of 2**ADDR_W words mapped at BASE_ADDR. Supports
//                FIXED and INCR bursts with programmable read and write
//                response latency.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - axi_sram_slave_if.slave (AW/W/B/AR/R channels)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          ADDR_W    = 16,
    parameter int          RD_LAT    = 2,
    parameter int          WR_LAT    = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    axi_sram_slave_if.slave bus
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam int         CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_WR_RESP = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic               rdy_q,    rdy_d;     // address channels open (IDLE, out of reset)
    logic [31:0]        addr_q,   addr_d;    // address of the beat being served
    logic [3:0]         id_q,     id_d;
    logic [7:0]         len_q,    len_d;
    logic [2:0]         size_q,   size_d;
    logic [1:0]         burst_q,  burst_d;
    logic [8:0]         beat_q,   beat_d;    // extra bit flags write overrun past len
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [1:0]         err_q,    err_d;     // worst write response so far
    logic               wready_q, wready_d;
    logic               rvalid_q, rvalid_d;
    logic [63:0]        rdata_q,  rdata_d;
    logic [1:0]         rresp_q,  rresp_d;
    logic               rlast_q,  rlast_d;
    logic [3:0]         rid_q,    rid_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q,  bresp_d;
    logic [3:0]         bid_q,    bid_d;

    logic [63:0] mem [0:(1 << ADDR_W) - 1];

    // ------------------------------------------------------------------
    // Address decode. Reads fetch the next beat at the handshake so that
    // beats can issue back to back; everything else uses the current one.
    // ------------------------------------------------------------------
    logic [31:0]       w_next_addr;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_off;
    logic [ADDR_W-1:0] w_acc_idx;
    logic [1:0]        w_acc_resp;
    logic [63:0]       w_rd_word;
    logic              w_len_hit;
    logic              w_overrun;
    logic              w_proto_err;
    logic [1:0]        w_wr_resp;
    logic              w_mem_we;
    logic              unused_off_bits;

    assign w_next_addr = (burst_q == BURST_INCR) ? (addr_q + (32'd1 << size_q)) : addr_q;
    assign w_acc_addr  = (state_q == ST_RD_DATA) ? w_next_addr : addr_q;
    assign w_acc_off   = w_acc_addr - BASE_ADDR;
    assign w_acc_idx   = w_acc_off[ADDR_W+2:3];
    assign unused_off_bits = ^w_acc_off[2:0];

    // Illegal burst/size dominates; otherwise anything outside the window
    // (including a wrapped offset below BASE) decodes as DECERR.
    assign w_acc_resp = ((burst_q > BURST_INCR) || (size_q > 3'd3)) ? RESP_SLVERR :
                        (w_acc_off[31:ADDR_W+3] != '0)              ? RESP_DECERR :
                                                                      RESP_OKAY;

    assign w_rd_word = mem[w_acc_idx];

    assign w_len_hit   = (beat_q == {1'b0, len_q});
    assign w_overrun   = (beat_q > {1'b0, len_q});
    assign w_proto_err = w_overrun || (bus.wlast != w_len_hit);
    assign w_wr_resp   = (w_proto_err && (w_acc_resp == RESP_OKAY)) ? RESP_SLVERR : w_acc_resp;

    assign w_mem_we = (state_q == ST_WR_DATA) && wready_q && bus.wvalid &&
                      (w_acc_resp == RESP_OKAY) && !w_overrun;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        addr_d   = addr_q;
        id_d     = id_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wready_d = wready_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rid_d    = rid_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        bid_d    = bid_q;

        case (state_q)
            ST_IDLE: begin
                rdy_d = 1'b1;
                // AW takes priority: arready is masked while awvalid is high.
                if (rdy_q && bus.awvalid) begin
                    addr_d   = bus.awaddr;
                    id_d     = bus.awid;
                    len_d    = bus.awlen;
                    size_d   = bus.awsize;
                    burst_d  = bus.awburst;
                    beat_d   = '0;
                    err_d    = RESP_OKAY;
                    wready_d = 1'b1;
                    rdy_d    = 1'b0;
                    state_d  = ST_WR_DATA;
                end else if (rdy_q && bus.arvalid) begin
                    addr_d  = bus.araddr;
                    id_d    = bus.arid;
                    len_d   = bus.arlen;
                    size_d  = bus.arsize;
                    burst_d = bus.arburst;
                    beat_d  = '0;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    rdy_d   = 1'b0;
                    state_d = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    rvalid_d = 1'b1;
                    rresp_d  = w_acc_resp;
                    rdata_d  = (w_acc_resp == RESP_OKAY) ? w_rd_word : 64'd0;
                    rlast_d  = (len_q == 8'd0);
                    rid_d    = id_q;
                    state_d  = ST_RD_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RD_DATA: begin
                if (bus.rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rdy_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + 9'd1;
                        addr_d  = w_next_addr;
                        rresp_d = w_acc_resp;
                        rdata_d = (w_acc_resp == RESP_OKAY) ? w_rd_word : 64'd0;
                        rlast_d = ((beat_q + 9'd1) == {1'b0, len_q});
                    end
                end
            end

            ST_WR_DATA: begin
                if (bus.wvalid) begin
                    addr_d = w_next_addr;
                    beat_d = beat_q + 9'd1;
                    if (w_wr_resp > err_q) begin
                        err_d = w_wr_resp;
                    end
                    // wlast always closes the burst, even when it arrives early.
                    if (bus.wlast) begin
                        wready_d = 1'b0;
                        cnt_d    = CNT_W'(WR_LAT - 1);
                        state_d  = ST_WR_WAIT;
                    end
                end
            end

            ST_WR_WAIT: begin
                if (cnt_q == '0) begin
                    bvalid_d = 1'b1;
                    bresp_d  = err_q;
                    bid_d    = id_q;
                    state_d  = ST_WR_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_WR_RESP: begin
                if (bus.bready) begin
                    bvalid_d = 1'b0;
                    rdy_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. rdy_q clears in reset so every ready is low until the
    // first clock after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b0;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            bid_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wready_q <= wready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rid_q    <= rid_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            bid_q    <= bid_d;
        end
    end

    // SRAM array: byte-enabled write port, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.wstrb[b]) begin
                    mem[w_acc_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.awready = rdy_q;
    assign bus.arready = rdy_q & ~bus.awvalid;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
// ============================================================================
//  Module      : tb_axi_sram_slave
//  Description : Self-checking bench for axi_sram_slave. Directed scenarios
//                followed by random FIXED/INCR traffic, all compared against
//                a word-indexed associative-array memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_sram_slave;

    localparam logic [31:0]     BASE      = 32'h8000_0000;
    localparam int              AW        = 16;
    localparam int              RDL       = 2;
    localparam int              WRL       = 1;
    localparam longint unsigned MEM_BYTES = 64'd8 << AW;
    localparam int              BUDGET    = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axi_sram_slave_if bus ();

    axi_sram_slave #(
        .BASE_ADDR (BASE),
        .ADDR_W    (AW),
        .RD_LAT    (RDL),
        .WR_LAT    (WRL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_asserts = 0;
    int n_fails   = 0;

    logic [63:0] model [longint unsigned];   // word index -> contents
    logic [63:0] wd [256];                    // per-beat write data
    logic [7:0]  ws [256];                    // per-beat write strobes

    // ------------------------------------------------------------------
    // Reference model helpers
    // ------------------------------------------------------------------
    function automatic logic [1:0] m_resp(input logic [31:0] a, input logic [2:0] sz,
                                          input logic [1:0] bt);
        longint unsigned ua;
        ua = 64'(a);
        if (bt > 2'd1 || sz > 3'd3) return 2'b10;
        if (ua < 64'(BASE) || ua >= 64'(BASE) + MEM_BYTES) return 2'b11;
        return 2'b00;
    endfunction

    function automatic longint unsigned m_idx(input logic [31:0] a);
        return (64'(a) - 64'(BASE)) / 8;
    endfunction

    function automatic logic [63:0] m_get(input logic [31:0] a);
        longint unsigned k;
        k = m_idx(a);
        if (model.exists(k)) return model[k];
        return 64'd0;
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] sz,
                                           input logic [1:0] bt);
        if (bt == 2'b01) return a + (32'd1 << sz);
        return a;
    endfunction

    // ------------------------------------------------------------------
    // Checking and clocking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, bus.rdata, 64'd0);
        check({tag, "_ctrl"},
              64'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.bresp, bus.bid,
                   bus.rvalid, bus.rresp, bus.rlast, bus.rid}), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Write burst; beats use wd[]/ws[]; wlast is raised on beat last_at.
    // ------------------------------------------------------------------
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at);
        logic [31:0] a;
        logic [1:0]  r;
        logic [1:0]  worst;
        logic [63:0] w;
        int          n;
        int          hold;
        a     = addr;
        worst = 2'b00;
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awid    = id;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        n = 0;
        while (bus.awready !== 1'b1 && n < BUDGET) begin tick(); n++; end
        check("aw_accept", 64'(bus.awready), 64'd1);
        if (bus.awready !== 1'b1) begin bus.awvalid = 1'b0; return; end
        tick();
        bus.awvalid = 1'b0;
        for (int i = 0; i <= last_at; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wd[i];
            bus.wstrb  = ws[i];
            bus.wlast  = (i == last_at);
            n = 0;
            while (bus.wready !== 1'b1 && n < BUDGET) begin tick(); n++; end
            check("w_accept", 64'(bus.wready), 64'd1);
            tick();
            r = m_resp(a, size, burst);
            if (r == 2'b00) begin
                w = m_get(a);
                for (int b = 0; b < 8; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                model[m_idx(a)] = w;
            end
            if (i == last_at && last_at != int'(len) && r == 2'b00) r = 2'b10;
            if (r > worst) worst = r;
            a = m_next(a, size, burst);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < BUDGET) begin tick(); n++; end
        check("wr_latency", 64'(n), 64'(WRL));
        check("bresp", 64'(bus.bresp), 64'(worst));
        check("bid", 64'(bus.bid), 64'(id));
        hold = $urandom_range(0, 2);
        for (int k = 0; k < hold; k++) begin
            tick();
            check("bvalid_hold", 64'(bus.bvalid), 64'd1);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("bvalid_done", 64'(bus.bvalid), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Read burst. mode 0: rready always 1; 1: random; 2: pattern 1,0,0,1.
    // Every cycle with rvalid high is checked, so stalls verify holding.
    // ------------------------------------------------------------------
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        logic [31:0] a;
        logic [1:0]  r;
        int          n;
        int          i;
        int          cyc;
        bit          rr;
        a = addr;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        n = 0;
        while (bus.arready !== 1'b1 && n < BUDGET) begin tick(); n++; end
        check("ar_accept", 64'(bus.arready), 64'd1);
        if (bus.arready !== 1'b1) begin bus.arvalid = 1'b0; return; end
        tick();
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < BUDGET) begin tick(); n++; end
        check("rd_latency", 64'(n), 64'(RDL));
        i   = 0;
        cyc = 0;
        while (i <= int'(len) && cyc < 4 * BUDGET) begin
            r = m_resp(a, size, burst);
            check("rvalid", 64'(bus.rvalid), 64'd1);
            check("rdata", bus.rdata, (r == 2'b00) ? m_get(a) : 64'd0);
            check("rresp", 64'(bus.rresp), 64'(r));
            check("rlast", 64'(bus.rlast), 64'(i == int'(len)));
            check("rid", 64'(bus.rid), 64'(id));
            case (mode)
                0:       rr = 1'b1;
                1:       rr = 1'($urandom_range(0, 1));
                default: rr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            bus.rready = rr;
            tick();
            bus.rready = 1'b0;
            if (rr) begin
                i++;
                a = m_next(a, size, burst);
            end
            cyc++;
        end
        check("rd_beats", 64'(i), 64'(len) + 64'd1);
        check("rvalid_done", 64'(bus.rvalid), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence followed by random traffic
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        logic [31:0] top;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bt;
        int          n;

        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
        bus.awsize  = '0;   bus.awburst = '0;
        bus.wvalid  = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
        bus.arsize  = '0;   bus.arburst = '0;
        bus.rready  = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        tick();
        check("idle_awready", 64'(bus.awready), 64'd1);
        check("idle_arready", 64'(bus.arready), 64'd1);

        // AW beats AR when both are valid in IDLE
        bus.awvalid = 1'b1;
        bus.arvalid = 1'b1;
        #1;
        check("prio_arready_masked", 64'(bus.arready), 64'd0);
        bus.awvalid = 1'b0;
        #1;
        check("prio_arready_open", 64'(bus.arready), 64'd1);
        bus.arvalid = 1'b0;
        tick();

        // Preload words 0..31
        for (int i = 0; i < 32; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'hFF;
        end
        do_write(BASE, 4'h1, 8'd31, 3'd3, 2'b01, 31);

        // Single-beat write then read of a known pattern
        wd[0] = 64'h1122_3344_5566_7788;
        ws[0] = 8'hFF;
        do_write(BASE + 32'd8, 4'h5, 8'd0, 3'd3, 2'b01, 0);
        check("known_word_model", m_get(BASE + 32'd8), 64'h1122_3344_5566_7788);
        do_read(BASE + 32'd8, 4'h9, 8'd0, 3'd3, 2'b01, 0);

        // INCR read of words 0..3, then the same with rready 1,0,0,1
        do_read(BASE, 4'h3, 8'd3, 3'd3, 2'b01, 0);
        do_read(BASE, 4'h6, 8'd3, 3'd3, 2'b01, 2);

        // Partial strobe write over a cleared word
        wd[0] = 64'd0;                     ws[0] = 8'hFF;
        do_write(BASE, 4'h2, 8'd0, 3'd3, 2'b01, 0);
        wd[0] = 64'hFFFF_FFFF_AAAA_AAAA;   ws[0] = 8'h0F;
        do_write(BASE, 4'h2, 8'd0, 3'd3, 2'b01, 0);
        check("strobe_model", m_get(BASE), 64'h0000_0000_AAAA_AAAA);
        do_read(BASE, 4'h4, 8'd0, 3'd3, 2'b01, 0);

        // Out-of-range read; illegal burst type write leaves memory alone
        do_read(32'h0000_1000, 4'h7, 8'd0, 3'd3, 2'b01, 0);
        wd[0] = {$urandom, $urandom};      ws[0] = 8'hFF;
        do_write(BASE + 32'd16, 4'hB, 8'd0, 3'd3, 2'b10, 0);
        do_read(BASE + 32'd16, 4'hC, 8'd0, 3'd3, 2'b01, 0);

        // Early wlast on beat 1 of a 4-beat burst
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(BASE + 32'd64, 4'hD, 8'd3, 3'd3, 2'b01, 1);
        do_read(BASE + 32'd64, 4'hD, 8'd3, 3'd3, 2'b01, 0);

        // INCR burst that runs off the top of the array
        top = 32'(64'(BASE) + MEM_BYTES - 64'd16);
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(top, 4'hE, 8'd3, 3'd3, 2'b01, 3);
        do_read(top, 4'hE, 8'd3, 3'd3, 2'b01, 1);

        // FIXED burst with random strobes, all beats landing on one word
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        do_write(BASE + 32'd40, 4'h8, 8'd3, 3'd3, 2'b00, 3);
        do_read(BASE + 32'd40, 4'h8, 8'd3, 3'd3, 2'b00, 1);

        // Reset during beat 2 of an 8-beat read
        bus.arvalid = 1'b1; bus.araddr = BASE; bus.arid = 4'hA;
        bus.arlen = 8'd7;   bus.arsize = 3'd3; bus.arburst = 2'b01;
        n = 0;
        while (bus.arready !== 1'b1 && n < BUDGET) begin tick(); n++; end
        tick();
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < BUDGET) begin tick(); n++; end
        for (int k = 0; k < 2; k++) begin
            check("rst_pre_beat", bus.rdata, m_get(BASE + 32'(8 * k)));
            bus.rready = 1'b1;
            tick();
            bus.rready = 1'b0;
        end
        check("rst_beat2_valid", 64'(bus.rvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midburst_reset");
        tick(); tick();
        check_all_zero("held_reset");
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_no_beat", 64'(bus.rvalid), 64'd0);
        do_read(BASE + 32'd8, 4'h1, 8'd1, 3'd3, 2'b01, 0);

        // Random traffic inside the preloaded region, with some out-of-range
        // and illegal-burst transactions mixed in
        for (int t = 0; t < 40; t++) begin
            a   = BASE + 32'(8 * $urandom_range(0, 20)) + 32'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'h1000_0000 + 32'($urandom_range(0, 255));
            len = 8'($urandom_range(0, 7));
            sz  = 3'($urandom_range(0, 3));
            bt  = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) bt = 2'b11;
            if ($urandom_range(0, 15) == 0) sz = 3'($urandom_range(4, 7));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wd[i] = {$urandom, $urandom};
                    ws[i] = 8'($urandom);
                end
                do_write(a, 4'($urandom), len, sz, bt, int'(len));
            end else begin
                do_read(a, 4'($urandom), len, sz, bt, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    // Global guard against a stuck handshake escaping the local bounds
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
